// File: rtl/occ_rom_arbiter_pkg.sv
// Shared definitions for the occurrence-ROM arbiter: default geometry,
// requester identities and a small index-width helper.
package occ_rom_arbiter_pkg;

    // Default geometry of the shared occurrence ROM port
    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int ROM_LAT_DEF = 2;

    // Requester slots: k-bound fetch, l-bound fetch, auxiliary path
    localparam int REQ_K   = 0;
    localparam int REQ_L   = 1;
    localparam int REQ_AUX = 2;

    // Symbolic view of the requester slots, handy when debugging waveforms
    typedef enum logic [1:0] {
        ID_K   = 2'd0,
        ID_L   = 2'd1,
        ID_AUX = 2'd2
    } req_id_e;

    // Width needed to hold an index in [0, n-1]; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/occ_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr (wrapping), as both a one-hot vector and a binary index.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    // Walk the requests starting at ptr and stop at the first asserted one
    always_comb begin
        int idx;
        logic [IDX_W-1:0] idx_sel;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_sel = IDX_W'(idx);
            if (!found && req[idx_sel]) begin
                found          = 1'b1;
                grant[idx_sel] = 1'b1;
                grant_idx      = idx_sel;
            end
        end
    end

endmodule

// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter and read sequencer for the single-port occurrence ROM.
// Accepts one address per cycle, issues it to the ROM the next cycle and
// carries the owner's one-hot tag through the fixed ROM latency so that each
// word comes back to the requester that asked for it, in grant order.
module occ_rom_arbiter
    import occ_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rom_en,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_data,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy
);

    localparam int PTR_W = idx_width(NUM_REQ);

    logic [PTR_W-1:0]              ptr_reg;
    logic [PTR_W-1:0]              ptr_next;
    logic [NUM_REQ-1:0]            pick_grant;
    logic [PTR_W-1:0]              pick_idx;
    logic                          pick_found;
    logic                          accept;
    logic [ADDR_W-1:0]             addr_arr [NUM_REQ];
    logic                          rom_en_reg;
    logic [ADDR_W-1:0]             rom_addr_reg;
    logic [ADDR_W-1:0]             rom_addr_next;
    // Stage s holds the owner of the read issued s cycles ago
    logic [ROM_LAT:0][NUM_REQ-1:0] tag_reg;
    logic                          busy_next;

    // Unpack the flat address bus into one word per requester
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    // Grant is suppressed during reset so nothing can be accepted then
    assign req_ready = rst ? '0 : pick_grant;
    assign accept    = !rst && pick_found;

    // Next pointer: one past the winner, holding when nobody was granted
    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            if (int'(pick_idx) == NUM_REQ - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = pick_idx + PTR_W'(1);
            end
        end
    end

    // Priority pointer register; requester 0 ranks first out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Address of the winner, or the previous address when idle
    always_comb begin
        rom_addr_next = rom_addr_reg;
        if (accept) begin
            rom_addr_next = addr_arr[pick_idx];
        end
    end

    // ROM issue stage: strobe and address registered one cycle after accept
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_en_reg   <= 1'b0;
            rom_addr_reg <= '0;
        end else begin
            rom_en_reg   <= accept;
            rom_addr_reg <= rom_addr_next;
        end
    end

    assign rom_en   = rom_en_reg;
    assign rom_addr = rom_addr_reg;

    // Ownership shift register; clearing it on reset drops reads in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_reg <= '0;
        end else begin
            tag_reg[0] <= accept ? pick_grant : '0;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    // Any owner tag still in the pipe means a read is outstanding
    always_comb begin
        busy_next = 1'b0;
        for (int s = 0; s <= ROM_LAT; s++) begin
            busy_next = busy_next | (|tag_reg[s]);
        end
    end

    assign busy      = busy_next;
    assign rsp_valid = tag_reg[ROM_LAT];
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Directed bench for occ_rom_arbiter with a two-cycle behavioural ROM.
module tb_occ_rom_arbiter;
    import occ_rom_arbiter_pkg::*;

    localparam int NR = NUM_REQ_DEF;
    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int RL = ROM_LAT_DEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    occ_rom_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Content of ROM word a
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {16'hDA7A, 6'd0, a};
    endfunction

    // Two-stage ROM: address sampled, then word presented one edge later
    logic [AW-1:0] rom_a1;
    always @(posedge clk) begin
        rom_a1   <= rom_addr;
        rom_data <= rom_word(rom_a1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b111;
        req_addr  = '0;

        // Reset state, with requests pending to show req_ready stays low
        next_cycle();
        @(negedge clk);
        check("rst_ready", req_ready, 3'b000);
        check("rst_rom_en", rom_en, 1'b0);
        check("rst_rom_addr", rom_addr, 10'h000);
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_busy", busy, 1'b0);
        next_cycle();
        rst = 1'b0;
        req_valid = 3'b000;

        // Single request from requester 1
        req_valid = 3'b010;
        set_addr(REQ_L, 10'h005);
        @(negedge clk);
        check("single_ready", req_ready, 3'b010);
        next_cycle();
        req_valid = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("single_rom_en", rom_en, (i == 1) ? 1'b1 : 1'b0);
            if (i == 1) check("single_rom_addr", rom_addr, 10'h005);
            check("single_rsp_valid", rsp_valid, (i == 3) ? 3'b010 : 3'b000);
            if (i == 3) check("single_rsp_data", rsp_data, rom_word(10'h005));
            check("single_busy", busy, (i <= 3) ? 1'b1 : 1'b0);
            next_cycle();
        end

        // All three continuously requesting straight out of reset
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_addr(REQ_K, 10'h001);
        set_addr(REQ_L, 10'h002);
        set_addr(REQ_AUX, 10'h003);
        req_valid = 3'b111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            $display("rr cycle %0d ready=%b rom_en=%b rsp=%b", i, req_ready, rom_en, rsp_valid);
            check("rr_ready", req_ready, 3'b001 << (i % 3));
            if (i >= 1) begin
                check("rr_rom_en", rom_en, 1'b1);
                check("rr_rom_addr", rom_addr, 10'((i - 1) % 3 + 1));
            end
            if (i >= 3) begin
                check("rr_rsp_valid", rsp_valid, 3'b001 << ((i - 3) % 3));
                check("rr_rsp_data", rsp_data, rom_word(10'((i - 3) % 3 + 1)));
            end
            next_cycle();
        end

        // Last grant above went to requester 2, so 0 outranks 2 now
        req_valid = 3'b101;
        @(negedge clk);
        check("ptr_first", req_ready, 3'b001);
        next_cycle();
        @(negedge clk);
        check("ptr_second", req_ready, 3'b100);
        next_cycle();
        req_valid = 3'b000;
        repeat (5) next_cycle();

        // Reset with two reads outstanding
        req_valid = 3'b010;
        set_addr(REQ_L, 10'h020);
        next_cycle();
        set_addr(REQ_L, 10'h021);
        next_cycle();
        req_valid = 3'b000;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_rsp_valid", rsp_valid, 3'b000);
            check("rstmid_busy", busy, 1'b0);
            next_cycle();
        end
        req_valid = 3'b111;
        @(negedge clk);
        check("rstmid_grant", req_ready, 3'b001);
        next_cycle();
        req_valid = 3'b000;
        repeat (5) next_cycle();

        // Requester 0 back-to-back, 0x010..0x013
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 4) ? 3'b001 : 3'b000;
            set_addr(REQ_K, 10'(16 + i));
            @(negedge clk);
            $display("b2b cycle %0d ready=%b rom_en=%b addr=%h rsp=%b data=%h",
                     i, req_ready, rom_en, rom_addr, rsp_valid, rsp_data);
            check("b2b_ready", req_ready, (i < 4) ? 3'b001 : 3'b000);
            check("b2b_rom_en", rom_en, (i >= 1 && i <= 4) ? 1'b1 : 1'b0);
            if (i >= 1 && i <= 4) check("b2b_rom_addr", rom_addr, 10'(16 + i - 1));
            check("b2b_rsp_valid", rsp_valid, (i >= 3 && i <= 6) ? 3'b001 : 3'b000);
            if (i >= 3 && i <= 6) check("b2b_rsp_data", rsp_data, rom_word(10'(16 + i - 3)));
            next_cycle();
        end

        // Withdrawn request: park ptr at 0, then 0 and 1 compete and 1 drops out
        req_valid = 3'b100;
        set_addr(REQ_AUX, 10'h033);
        @(negedge clk);
        check("wd_setup", req_ready, 3'b100);
        next_cycle();
        req_valid = 3'b011;
        set_addr(REQ_K, 10'h030);
        set_addr(REQ_L, 10'h031);
        @(negedge clk);
        check("wd_grant0", req_ready, 3'b001);
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        check("wd_rom_addr", rom_addr, 10'h030);
        next_cycle();
        // Pointer sits at 1: requester 2 must beat requester 0
        req_valid = 3'b101;
        @(negedge clk);
        check("wd_ptr", req_ready, 3'b100);
        next_cycle();
        req_valid = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wd_no_rsp1", rsp_valid[REQ_L], 1'b0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/occ_rom_arbiter.md
# occ_rom_arbiter

Round-robin arbiter and read sequencer that shares the single-port occurrence ROM among up to three lookup requesters. Each requester is one (k, l)-interval fetch path of the search engine, sitting behind the parameter stage. The block accepts one address per cycle, issues it to the ROM, and tracks ownership through the fixed ROM read latency. It returns each data word to the requester that issued it, in issue order.

## Interface
- NUM_REQ, 3, number of requesters
- ADDR_W, 10, ROM address width
- DATA_W, 32, ROM data width
- ROM_LAT, 2, cycles from rom_en to valid rom_data (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; accept when req_valid[i] & req_ready[i]
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_en
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester
- rsp_data  out  DATA_W  response word; equals rom_data
- busy  out  1  high while any read is in flight

## Operation
- Arbitration: each cycle, grant the first requester with req_valid=1, searching upward (with wrap) from pointer ptr.
- req_ready is combinational from req_valid and ptr. It is at most one-hot and is all-zero when no request is pending.
- Pointer: on a grant to index g, ptr ← (g+1) mod NUM_REQ. With no grant, ptr holds.
- Starvation bound: a continuously-requesting requester waits at most NUM_REQ-1 grants.
- Requesters hold req_valid and req_addr stable until accepted. A requester may drop req_valid before it is accepted; in that case, no read is issued for it.
- Issue: an accepted address is registered into rom_addr with rom_en=1 on the next cycle. rom_en=0 in cycles with no accept. rom_addr holds its last value when idle.
- Tag pipeline: the one-hot grant is shifted through ROM_LAT+1 stages. The last stage drives rsp_valid, and rsp_data is passed through from rom_data.
- busy = OR of all tag stages.
- No back-pressure on responses: requesters must sink rsp_valid in the cycle it is asserted.
- Throughput is one read per cycle, and responses return in grant order.
- Reset:
  - Next edge: ptr=0 (requester 0 has highest priority), all tag stages cleared, rom_en=0, rom_addr=0, rsp_valid=0, busy=0.
  - Reads in flight at reset are discarded: no rsp_valid is produced for them, even if rom_data later changes.
  - req_ready is combinationally 0 while rst=1.

## Timing
- Accept at cycle t → rom_en/rom_addr at t+1 → rsp_valid/rsp_data at t+1+ROM_LAT. With defaults, latency is 3 cycles.
- Simultaneous grant and response in the same cycle are independent and always allowed.
- The pointer update and the tag shift both happen on the grant's clock edge.
- The first grant is possible in the first cycle with rst=0.

## Structure
- Shared package holds:
  - NUM_REQ, ADDR_W, DATA_W and ROM_LAT defaults.
  - Requester index constants REQ_K=0, REQ_L=1, REQ_AUX=2.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and grant index.
  - Instantiated once; the pointer register lives in occ_rom_arbiter.

## Test plan
- Single request: req_valid=3'b010, addr1=0x005 at t. Required: req_ready=3'b010 at t; rom_en=1, rom_addr=0x005 at t+1; rsp_valid=3'b010 with rsp_data=ROM[0x005] at t+3.
- All three requesting continuously from reset, addresses 0x001/0x002/0x003. Required: grants 0,1,2,0,1,2…; rom_en high every cycle; rsp_valid sequence 001,010,100 repeating, with matching data.
- Pointer check: after a grant to requester 2, assert req_valid=3'b101. Required: requester 0 is granted first, then requester 2.
- Reset mid-flight: two reads are outstanding and rst=1 for one cycle. Required: rsp_valid=0 and busy=0 from the next cycle onward; the next grant goes to requester 0.
- Single requester back-to-back, addresses 0x010..0x013 on consecutive cycles. Required: four consecutive rom_en cycles and four consecutive rsp_valid pulses carrying the correct words.
- Withdrawn request: req_valid[1] is dropped while requester 0 is being granted. Required: no read is ever issued for requester 1, and ptr advances only past 0.
